// File: rtl/kuzn_block_feeder_if.sv
// Stream and cipher-side signal bundle for kuzn_block_feeder.
// Signal names keep their original _i/_o suffixes as seen from the feeder.
// The master modport is the feeder. The slave modport is its surroundings:
// the SoC stream source/sink plus the cipher core.
interface kuzn_block_feeder_if #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned DATA_W = 128
);
    // input word stream
    logic              s_valid_i;
    logic              s_ready_o;
    logic [WORD_W-1:0] s_data_i;

    // output word stream
    logic              m_valid_o;
    logic              m_ready_i;
    logic [WORD_W-1:0] m_data_o;
    logic              m_last_o;

    // cipher core handshake
    logic              cph_req_o;
    logic [DATA_W-1:0] cph_data_o;
    logic              cph_busy_i;
    logic              cph_valid_i;
    logic [DATA_W-1:0] cph_data_i;
    logic              cph_ack_o;

    modport master (
        input  s_valid_i, s_data_i, m_ready_i,
        input  cph_busy_i, cph_valid_i, cph_data_i,
        output s_ready_o, m_valid_o, m_data_o, m_last_o,
        output cph_req_o, cph_data_o, cph_ack_o
    );

    modport slave (
        output s_valid_i, s_data_i, m_ready_i,
        output cph_busy_i, cph_valid_i, cph_data_i,
        input  s_ready_o, m_valid_o, m_data_o, m_last_o,
        input  cph_req_o, cph_data_o, cph_ack_o
    );
endinterface

// File: rtl/kuzn_block_feeder.sv
// Word-stream front end for the kuznechik cipher core.
// Four input words (first word = bits [DATA_W-1:DATA_W-WORD_W]) are packed
// into one block, which is handed to the cipher with a one-cycle request.
// The result is collected with the valid/ack handshake and streamed out as
// four words, first word from the top of the block.
// A one-block input buffer lets the next block arrive while the current one
// is in the cipher or still draining. DATA_W must equal 4*WORD_W.
module kuzn_block_feeder #(
    parameter int unsigned WORD_W  = 32,
    parameter int unsigned DATA_W  = 128,
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    kuzn_block_feeder_if.master bus,
    output logic             timeout_o,
    output logic [CNT_W-1:0] blk_cnt_o
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT) + 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        C_IDLE,
        C_WAIT,
        C_DRAIN
    } state_e;

    state_e            state_q;

    // input assembler
    logic [DATA_W-1:0] in_buf_q;
    logic [1:0]        in_cnt_q;
    logic [1:0]        in_cnt_d;
    logic              in_full_q;

    // cipher side and output serializer
    logic [DATA_W-1:0] cph_data_q;
    logic              req_q;
    logic              ack_q;
    logic              ack_prev_q;
    logic [DATA_W-1:0] out_buf_q;
    logic [1:0]        wcnt_q;
    logic              m_valid_q;
    logic              m_last_q;
    logic [TMO_W-1:0]  tmo_q;
    logic [TMO_W-1:0]  tmo_d;
    logic              timeout_q;
    logic [CNT_W-1:0]  blk_cnt_q;

    logic              s_hs;
    logic              m_hs;
    logic              launch;
    logic              stale_flush;

    assign s_hs = bus.s_valid_i && !in_full_q;
    assign m_hs = m_valid_q && bus.m_ready_i;

    // Launch decision and counter next-states.
    // The cipher holds valid for one cycle after our ack, so a stale flush is
    // suppressed for the ack cycle and the one after it; otherwise that
    // residual valid would be acknowledged a second time.
    always_comb begin
        launch      = 1'b0;
        stale_flush = 1'b0;
        in_cnt_d    = in_cnt_q + 2'd1;
        tmo_d       = (tmo_q == TMO_LAST) ? tmo_q : tmo_q + TMO_W'(1);
        if (state_q == C_IDLE) begin
            stale_flush = bus.cph_valid_i && !ack_q && !ack_prev_q;
            launch      = in_full_q && !bus.cph_busy_i && !bus.cph_valid_i;
        end
    end

    // Input assembler: shift words in, mark the buffer full on the 4th word.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            in_buf_q  <= '0;
            in_cnt_q  <= '0;
            in_full_q <= 1'b0;
        end else begin
            if (s_hs) begin
                in_buf_q <= {in_buf_q[DATA_W-WORD_W-1:0], bus.s_data_i};
                in_cnt_q <= in_cnt_d;
                if (in_cnt_q == 2'd3) begin
                    in_full_q <= 1'b1;
                end
            end else if (launch) begin
                in_full_q <= 1'b0;
            end
        end
    end

    // Cipher FSM: launch, wait for the result with a timeout, drain 4 words.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= C_IDLE;
            cph_data_q <= '0;
            req_q      <= 1'b0;
            ack_q      <= 1'b0;
            ack_prev_q <= 1'b0;
            out_buf_q  <= '0;
            wcnt_q     <= '0;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
            tmo_q      <= '0;
            timeout_q  <= 1'b0;
            blk_cnt_q  <= '0;
        end else begin
            req_q      <= 1'b0;
            ack_q      <= 1'b0;
            ack_prev_q <= ack_q;
            case (state_q)
                C_IDLE: begin
                    if (stale_flush) begin
                        ack_q <= 1'b1;
                    end
                    if (launch) begin
                        cph_data_q <= in_buf_q;
                        req_q      <= 1'b1;
                        tmo_q      <= '0;
                        state_q    <= C_WAIT;
                    end
                end
                C_WAIT: begin
                    tmo_q <= tmo_d;
                    if (tmo_d == TMO_LAST) begin
                        timeout_q <= 1'b1;
                    end
                    if (bus.cph_valid_i) begin
                        out_buf_q <= bus.cph_data_i;
                        ack_q     <= 1'b1;
                        wcnt_q    <= '0;
                        m_valid_q <= 1'b1;
                        m_last_q  <= 1'b0;
                        state_q   <= C_DRAIN;
                    end
                end
                C_DRAIN: begin
                    if (m_hs) begin
                        if (wcnt_q == 2'd3) begin
                            m_valid_q <= 1'b0;
                            m_last_q  <= 1'b0;
                            blk_cnt_q <= blk_cnt_q + CNT_W'(1);
                            state_q   <= C_IDLE;
                        end else begin
                            out_buf_q <= {out_buf_q[DATA_W-WORD_W-1:0], {WORD_W{1'b0}}};
                            wcnt_q    <= wcnt_q + 2'd1;
                            m_last_q  <= (wcnt_q == 2'd2);
                        end
                    end
                end
                default: begin
                    state_q <= C_IDLE;
                end
            endcase
        end
    end

    assign bus.s_ready_o  = !in_full_q;
    assign bus.m_valid_o  = m_valid_q;
    assign bus.m_data_o   = out_buf_q[DATA_W-1 -: WORD_W];
    assign bus.m_last_o   = m_last_q;
    assign bus.cph_req_o  = req_q;
    assign bus.cph_data_o = cph_data_q;
    assign bus.cph_ack_o  = ack_q;
    assign timeout_o      = timeout_q;
    assign blk_cnt_o      = blk_cnt_q;

endmodule

// File: tb/tb_kuzn_block_feeder.sv
// Directed bench for kuzn_block_feeder with a behavioural cipher model.
// The model returns the GOST R 34.12-2015 reference ciphertext for the
// reference plaintext and a simple rotate/xor mapping for any other block.
module tb_kuzn_block_feeder;
    localparam int WORD_W  = 32;
    localparam int DATA_W  = 128;
    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 16;
    localparam int LAT     = 6;

    localparam logic [127:0] PT0 = 128'h1122334455667700ffeeddccbbaa9988;
    localparam logic [127:0] CT0 = 128'h7f679d90bebc24305a468d42b9d4edcd;
    localparam logic [127:0] KX  = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic timeout;
    logic [CNT_W-1:0] blk_cnt;

    always #5 clk = ~clk;

    kuzn_block_feeder_if #(.WORD_W(WORD_W), .DATA_W(DATA_W)) bus ();

    kuzn_block_feeder #(
        .WORD_W(WORD_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk), .reset_i(reset), .bus(bus),
        .timeout_o(timeout), .blk_cnt_o(blk_cnt)
    );

    function automatic logic [127:0] cipher_f(input logic [127:0] p);
        if (p == PT0) return CT0;
        return {p[95:0], p[127:96]} ^ KX;
    endfunction

    // ---------------- cipher model ----------------
    typedef enum logic [1:0] {M_IDLE, M_RUN, M_FIN, M_DONE} mst_e;
    mst_e mst;
    int mcnt;
    logic [127:0] mres;
    logic hang;
    logic mrst;

    always @(posedge clk) begin
        if (mrst) begin
            mst  <= M_IDLE;
            mcnt <= 0;
            mres <= '0;
        end else begin
            case (mst)
                M_IDLE: if (bus.cph_req_o) begin
                    mres <= cipher_f(bus.cph_data_o);
                    mcnt <= LAT;
                    mst  <= M_RUN;
                end
                M_RUN: if (!hang) begin
                    if (mcnt == 0) mst <= M_FIN;
                    else mcnt <= mcnt - 1;
                end
                M_FIN:  if (bus.cph_ack_o) mst <= M_DONE;
                default: mst <= M_IDLE;
            endcase
        end
    end

    assign bus.cph_busy_i  = (mst == M_RUN);
    assign bus.cph_valid_i = (mst == M_FIN) || (mst == M_DONE);
    assign bus.cph_data_i  = mres;

    // ---------------- monitors ----------------
    logic [31:0] outq[$];
    logic        lastq[$];
    int req_cnt = 0;
    int req_viol = 0;
    int ack_cnt = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.m_valid_o && bus.m_ready_i) begin
                outq.push_back(bus.m_data_o);
                lastq.push_back(bus.m_last_o);
            end
            if (bus.cph_ack_o) ack_cnt <= ack_cnt + 1;
        end
    end

    always @(posedge clk) begin
        if (bus.cph_req_o) begin
            req_cnt <= req_cnt + 1;
            if (bus.cph_busy_i || bus.cph_valid_i) req_viol <= req_viol + 1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking helpers ----------------
    int passed = 0;
    int fails  = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w);
        bus.s_valid_i = 1'b1;
        bus.s_data_i  = w;
        for (int i = 0; i < 200 && !bus.s_ready_o; i++) step();
        if (!bus.s_ready_o) chk("s_ready_wait", {127'd0, bus.s_ready_o}, 128'd1);
        step();
    endtask

    task automatic send_block(input logic [127:0] b, input bit drop);
        for (int k = 0; k < 4; k++) send_word(b[127-32*k -: 32]);
        if (drop) bus.s_valid_i = 1'b0;
        chk("s_ready_low_when_full", {127'd0, bus.s_ready_o}, 128'd0);
    endtask

    task automatic wait_words(input int n);
        for (int i = 0; i < 400 && outq.size() < n; i++) step();
        chk("word_count", outq.size(), n);
    endtask

    task automatic check_words(input int base, input logic [127:0] res);
        logic [127:0] r;
        r = res;
        for (int k = 0; k < 4; k++) begin
            if (base + k < outq.size()) begin
                chk("out_word", outq[base+k], r[127-32*k -: 32]);
                chk("out_last", {127'd0, lastq[base+k]}, (k == 3) ? 128'd1 : 128'd0);
            end else begin
                chk("out_word_missing", outq.size(), base + k + 1);
            end
        end
    endtask

    task automatic check_reset_values();
        chk("rst_s_ready",  {127'd0, bus.s_ready_o}, 128'd1);
        chk("rst_m_valid",  {127'd0, bus.m_valid_o}, 128'd0);
        chk("rst_m_last",   {127'd0, bus.m_last_o},  128'd0);
        chk("rst_req",      {127'd0, bus.cph_req_o}, 128'd0);
        chk("rst_ack",      {127'd0, bus.cph_ack_o}, 128'd0);
        chk("rst_timeout",  {127'd0, timeout},       128'd0);
        chk("rst_blk_cnt",  blk_cnt,                 128'd0);
        chk("rst_cph_data", bus.cph_data_o,          128'd0);
        chk("rst_m_data",   bus.m_data_o,            128'd0);
    endtask

    // ---------------- directed sequence ----------------
    logic [127:0] b1, b2, b3, b4, b5, b6, b7, b8, b9, exp_blk;
    int rc, a0, q0;
    logic [31:0] hd;
    logic hl;
    bit stable;

    initial begin
        b1 = 128'h00010203_04050607_08090a0b_0c0d0e0f;
        b2 = 128'hdeadbeef_cafebabe_01234567_89abcdef;
        b3 = 128'hffffffff_00000000_a5a5a5a5_5a5a5a5a;
        b4 = 128'h13579bdf_2468ace0_11111111_22222222;
        b5 = 128'h33333333_44444444_55555555_66666666;
        b6 = 128'h76543210_fedcba98_0badf00d_feedface;
        b7 = 128'h99999999_88888888_77777777_66666666;
        b8 = 128'h01020304_05060708_090a0b0c_0d0e0f10;
        b9 = 128'haaaa5555_5555aaaa_c3c3c3c3_3c3c3c3c;

        bus.s_valid_i = 1'b0;
        bus.s_data_i  = '0;
        bus.m_ready_i = 1'b1;
        hang = 1'b0;
        mrst = 1'b1;
        reset = 1'b1;

        // reset state
        repeat (3) step();
        check_reset_values();
        reset = 1'b0;
        mrst  = 1'b0;
        step();

        // single block with the reference vector
        send_block(PT0, 1'b1);
        step();
        chk("req_after_4th_word", {127'd0, bus.cph_req_o}, 128'd1);
        chk("req_data", bus.cph_data_o, PT0);
        step();
        chk("req_one_cycle", {127'd0, bus.cph_req_o}, 128'd0);
        chk("s_ready_after_launch", {127'd0, bus.s_ready_o}, 128'd1);
        wait_words(4);
        check_words(0, CT0);
        chk("blk_cnt_1", blk_cnt, 128'd1);
        chk("req_cnt_1", req_cnt, 128'd1);

        // three blocks back to back, s_valid held high
        send_block(b1, 1'b0);
        send_block(b2, 1'b0);
        send_block(b3, 1'b1);
        wait_words(16);
        check_words(4,  cipher_f(b1));
        check_words(8,  cipher_f(b2));
        check_words(12, cipher_f(b3));
        chk("blk_cnt_4", blk_cnt, 128'd4);
        chk("req_cnt_4", req_cnt, 128'd4);

        // output backpressure mid-drain with the next block buffered
        bus.m_ready_i = 1'b0;
        send_block(b4, 1'b0);
        send_block(b5, 1'b1);
        for (int i = 0; i < 200 && !bus.m_valid_o; i++) step();
        chk("drain_started", {127'd0, bus.m_valid_o}, 128'd1);
        bus.m_ready_i = 1'b1;
        step();
        step();
        bus.m_ready_i = 1'b0;
        rc = req_cnt;
        hd = bus.m_data_o;
        hl = bus.m_last_o;
        stable = 1'b1;
        repeat (20) begin
            step();
            if (bus.m_data_o !== hd || bus.m_last_o !== hl || bus.m_valid_o !== 1'b1) stable = 1'b0;
        end
        exp_blk = cipher_f(b4);
        chk("held_word", hd, exp_blk[63:32]);
        chk("held_last", {127'd0, hl}, 128'd0);
        chk("held_stable", {127'd0, stable}, 128'd1);
        chk("req_deferred", req_cnt, rc);
        bus.m_ready_i = 1'b1;
        wait_words(24);
        check_words(16, cipher_f(b4));
        check_words(20, cipher_f(b5));
        chk("blk_cnt_6", blk_cnt, 128'd6);

        // timeout with a silent cipher, then a late result
        hang = 1'b1;
        send_block(b6, 1'b1);
        for (int i = 0; i < 50 && !bus.cph_req_o; i++) step();
        chk("tmo_req_seen", {127'd0, bus.cph_req_o}, 128'd1);
        repeat (14) step();
        chk("timeout_not_yet", {127'd0, timeout}, 128'd0);
        step();
        chk("timeout_rise", {127'd0, timeout}, 128'd1);
        repeat (10) step();
        chk("timeout_sticky", {127'd0, timeout}, 128'd1);
        hang = 1'b0;
        wait_words(28);
        check_words(24, cipher_f(b6));
        chk("blk_cnt_7", blk_cnt, 128'd7);
        chk("timeout_after_late", {127'd0, timeout}, 128'd1);

        // stale result after a feeder-only reset
        hang = 1'b1;
        send_block(b7, 1'b1);
        for (int i = 0; i < 50 && !bus.cph_req_o; i++) step();
        step();
        step();
        reset = 1'b1;
        hang  = 1'b0;
        repeat (12) step();
        chk("model_holds_valid", {127'd0, bus.cph_valid_i}, 128'd1);
        reset = 1'b0;
        a0 = ack_cnt;
        q0 = outq.size();
        repeat (10) step();
        chk("stale_ack_once", ack_cnt - a0, 128'd1);
        chk("stale_no_words", outq.size(), q0);
        chk("stale_blk_cnt", blk_cnt, 128'd0);
        chk("stale_m_valid", {127'd0, bus.m_valid_o}, 128'd0);
        send_block(b8, 1'b1);
        wait_words(q0 + 4);
        check_words(q0, cipher_f(b8));
        chk("blk_cnt_after_stale", blk_cnt, 128'd1);

        // reset after a partial block
        send_word(32'hbad0bad0);
        send_word(32'hbad1bad1);
        bus.s_valid_i = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_reset_values();
        q0 = outq.size();
        send_block(b9, 1'b1);
        wait_words(q0 + 4);
        check_words(q0, cipher_f(b9));
        chk("blk_cnt_after_partial", blk_cnt, 128'd1);

        chk("req_only_when_free", req_viol, 128'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/kuzn_block_feeder.md
Name: kuzn_block_feeder

Overview:
- Word-stream front end for kuznechik_cipher. It packs four 32-bit input words into a 128-bit block and issues a request to the cipher.
- It collects the cipher result with the valid/ack handshake and serializes the 128-bit result into four 32-bit output words.
- The next input block is accepted while the current block is being ciphered or drained (one-block input buffer).
- It sits between the SoC stream/bus side and the cipher core.

Parameters:
- WORD_W, 32, stream word width; DATA_W must equal 4*WORD_W.
- DATA_W, 128, cipher block width.
- TIMEOUT, 1024, cycles in C_WAIT before timeout_o is raised.
- CNT_W, 16, width of blk_cnt_o.

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- reset_i  in  1  synchronous, active-high reset.
- s_valid_i  in  1  input word valid.
- s_ready_o  out  1  input word ready.
- s_data_i  in  WORD_W  input word; first word of a block = block bits [127:96].
- m_valid_o  out  1  output word valid.
- m_ready_i  in  1  output word ready.
- m_data_o  out  WORD_W  output word; first word = result bits [127:96].
- m_last_o  out  1  high with the 4th word of each block.
- cph_req_o  out  1  one-cycle request pulse to the cipher.
- cph_data_o  out  DATA_W  block to the cipher; stable from the request until the next request.
- cph_busy_i  in  1  cipher busy.
- cph_valid_i  in  1  cipher result valid; held until ack.
- cph_data_i  in  DATA_W  cipher result.
- cph_ack_o  out  1  one-cycle acknowledge pulse.
- timeout_o  out  1  sticky: the cipher did not respond within TIMEOUT cycles.
- blk_cnt_o  out  CNT_W  number of completed blocks (all 4 words drained); wraps modulo 2^CNT_W.

Behaviour:
- Reset values: s_ready_o=1, m_valid_o=0, m_last_o=0, cph_req_o=0, cph_ack_o=0, timeout_o=0, blk_cnt_o=0, cph_data_o=0, m_data_o=0. Internal counters are 0, in_full=0, FSM is in C_IDLE. Reset mid-block discards all partial data.

Input assembler:
- s_ready_o = !in_full.
- On s_valid_i&&s_ready_o: in_buf <= {in_buf[DATA_W-WORD_W-1:0], s_data_i}; in_cnt increments.
- On the 4th word, in_cnt wraps to 0 and in_full<=1.
- in_full clears only on launch (C_IDLE request). Handshake and launch cannot coincide because ready is low while full.

Cipher FSM (C_IDLE, C_WAIT, C_DRAIN):
- C_IDLE, in_full && !cph_busy_i && !cph_valid_i: cph_data_o<=in_buf, cph_req_o<=1, in_full<=0, tmo_cnt<=0, go to C_WAIT. The request is therefore seen one cycle after the 4th input word at the earliest.
- C_IDLE, cph_valid_i=1 (stale result, e.g. after a feeder-only reset): pulse cph_ack_o for one cycle. The data is discarded, blk_cnt_o is unchanged, and the FSM stays in C_IDLE. Launch has priority over neither; the stale flush happens first.
- C_WAIT: cph_req_o<=0, so the request is exactly 1 cycle. tmo_cnt increments and saturates.
  - When tmo_cnt reaches TIMEOUT-1, timeout_o<=1 (sticky until reset). The FSM keeps waiting.
  - When cph_valid_i=1: out_buf<=cph_data_i, cph_ack_o<=1 (1 cycle), word counter <=0, go to C_DRAIN.
- C_DRAIN: m_valid_o=1 and m_data_o=out_buf[127:96]. On each m handshake, shift out_buf left by WORD_W.
  - m_last_o=1 on the 4th word.
  - After the 4th handshake: m_valid_o<=0, blk_cnt_o++, go to C_IDLE.
  - m_data_o and m_last_o stay stable while m_valid_o && !m_ready_i.
- The cipher keeps valid high one cycle after ack. C_DRAIN lasts ≥4 cycles, so C_IDLE never sees that residual valid as stale.
- Input overlap: the next block may be fully buffered during C_WAIT or C_DRAIN. It launches on the first C_IDLE cycle.
- Throughput bound: one block per (cipher latency + 1 + 4 + 1) cycles with m_ready_i tied high.

Test Plan:
- Key schedule: standard GOST R 34.12-2015 test key schedule.
- Single block: words 11223344,55667700,ffeeddcc,bbaa9988 with m_ready_i=1 -> cph_req_o pulses once, 1 cycle after the 4th word, with cph_data_o=1122334455667700ffeeddccbbaa9988. Output words are 7f679d90,bebc2430,5a468d42,b9d4edcd, m_last_o is high on the last word, and blk_cnt_o=1.
- Back-to-back: 3 blocks streamed with s_valid_i always high -> s_ready_o drops after each 4-word block until launch. There are 12 output words in order, blk_cnt_o=3, and each cph_req_o occurs only while cph_busy_i=0 and cph_valid_i=0.
- Output backpressure: m_ready_i low for 20 cycles mid-drain -> m_data_o/m_last_o are held constant, no words are lost or duplicated, and the next request is deferred until drain completes.
- Timeout: cipher model never asserts valid, TIMEOUT=16 -> timeout_o rises 15 cycles after the request cycle and stays high; a later valid still completes the block normally.
- Stale flush: reset the feeder only while the cipher is in FIN (valid=1) -> one cph_ack_o pulse in C_IDLE, no output words, blk_cnt_o=0, and the next block processes correctly.
- Reset mid-input: 2 words sent, then reset_i for 1 cycle -> s_ready_o=1, all outputs at reset values; a following 4-word block produces a correct result.
